// File: rtl/vec_and_resp_checker.sv
// ---------------------------------------------------------------------------
// vec_and_resp_checker
//
// Response checker for the 9-bit AND-vector unit. Each applied stimulus
// pair (a, b) arrives together with the unit's outputs. The checker
// recomputes the expected result, compares it, counts vectors and
// mismatches, records the first failure, and reports pass/fail/timeout
// once a programmed run completes.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   start           single-cycle pulse arming a run (IDLE or DONE only)
//   num_vec         number of vectors expected, sampled on accepted start
//   in_valid        a, b, out1, out2, out3 are valid this cycle
//   a, b            stimulus operands
//   out1/out2/out3  unit outputs: &(a&b), |(a&b), a&b
//   busy / done     run in progress / run finished
//   pass            no mismatch and no timeout (meaningful while done)
//   timeout         run aborted by the idle watchdog
//   err_pulse       one-cycle pulse per mismatching vector
//   vec_cnt         vectors compared this run
//   err_cnt         mismatching vectors, saturating
//   first_err_idx   0-based vector index of the first mismatch
//   first_err_mask  {out3_bad, out2_bad, out1_bad} of the first mismatch
//
// TIMEOUT must be at least 1.
// ---------------------------------------------------------------------------
module vec_and_resp_checker #(
    parameter int W       = 9,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             out1,
    input  logic             out2,
    input  logic [W-1:0]     out3,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             err_pulse,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [2:0]       first_err_mask
);

    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] target;
    logic [IW-1:0]    idle_cnt;

    logic             s1_valid;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [W-1:0]     s1_out3;
    logic             s1_out1;
    logic             s1_out2;

    logic [W-1:0]     exp3;
    logic             exp1;
    logic             exp2;
    logic [2:0]       mask;
    logic             mismatch;
    logic [CNT_W:0]   cnt_sum;
    logic             run_complete;
    logic             idle_expire;
    logic             accept;

    // Expected-value model and compare on the stage-1 registers, plus the
    // run-termination conditions. cnt_sum is one bit wider so a target of
    // all-ones cannot wrap when the final compare is in flight.
    always_comb begin
        exp3         = s1_a & s1_b;
        exp1         = &exp3;
        exp2         = |exp3;
        mask         = {s1_out3 != exp3, s1_out2 != exp2, s1_out1 != exp1};
        mismatch     = |mask;
        cnt_sum      = {1'b0, vec_cnt} + {{CNT_W{1'b0}}, s1_valid};
        run_complete = (cnt_sum == {1'b0, target});
        idle_expire  = !in_valid && (idle_cnt == IW'(TIMEOUT - 1));
        // Once the target is reached this cycle, any further vector is
        // beyond the run and must not enter the pipeline.
        accept       = (state == S_RUN) && in_valid && !run_complete;
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == '0) && !timeout;

    // Single sequential block: stage-1 capture, stage-2 counting and the
    // run FSM. A start clears the run results and is written last so it
    // takes priority over a compare completing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            target         <= '0;
            idle_cnt       <= '0;
            s1_valid       <= 1'b0;
            s1_a           <= '0;
            s1_b           <= '0;
            s1_out3        <= '0;
            s1_out1        <= 1'b0;
            s1_out2        <= 1'b0;
            timeout        <= 1'b0;
            err_pulse      <= 1'b0;
            vec_cnt        <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_mask <= '0;
        end else begin
            err_pulse <= 1'b0;
            s1_valid  <= accept;
            if (accept) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_out3 <= out3;
                s1_out1 <= out1;
                s1_out2 <= out2;
            end

            // err_cnt never returns to zero within a run (it saturates),
            // so zero identifies the first mismatch of the run.
            if (s1_valid) begin
                vec_cnt <= vec_cnt + CNT_W'(1);
                if (mismatch) begin
                    err_pulse <= 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                    if (err_cnt == '0) begin
                        first_err_idx  <= vec_cnt;
                        first_err_mask <= mask;
                    end
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_RUN;
                        target         <= num_vec;
                        idle_cnt       <= '0;
                        timeout        <= 1'b0;
                        err_pulse      <= 1'b0;
                        vec_cnt        <= '0;
                        err_cnt        <= '0;
                        first_err_idx  <= '0;
                        first_err_mask <= '0;
                    end
                end
                S_RUN: begin
                    if (run_complete) begin
                        state <= S_DONE;
                    end else if (idle_expire) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                    end else if (in_valid) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_and_resp_checker.sv
// ---------------------------------------------------------------------------
// tb_vec_and_resp_checker
//
// Directed bench for vec_and_resp_checker. Two instances share the vector
// inputs: one with 8-bit counters, one with 2-bit counters for saturation.
// Expected per-vector results are queued when a vector is driven and
// popped on the cycle the checker should report them.
// ---------------------------------------------------------------------------
module tb_vec_and_resp_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [8:0] a, b, out3;
    logic       out1, out2;

    logic       start1, start2;
    logic [7:0] num_vec1;
    logic [1:0] num_vec2;

    logic       busy1, done1, pass1, timeout1, err_pulse1;
    logic [7:0] vec_cnt1, err_cnt1, first_idx1;
    logic [2:0] first_mask1;

    logic       busy2, done2, pass2, timeout2, err_pulse2;
    logic [1:0] vec_cnt2, err_cnt2, first_idx2;
    logic [2:0] first_mask2;

    // Observation mux selecting the instance under test
    logic       sel;
    logic       o_busy, o_done, o_pass, o_timeout, o_err_pulse;
    logic [7:0] o_vec_cnt, o_err_cnt, o_first_idx;
    logic [2:0] o_mask;

    typedef struct {
        int   due;
        logic pulse;
        int   vec;
    } sb_t;

    sb_t sbq[$];
    int  cyc       = 0;
    int  model_vec = 0;
    int  n_checks  = 0;
    int  n_pass    = 0;
    int  n_fail    = 0;

    always #5 clk = ~clk;

    vec_and_resp_checker #(.W(9), .CNT_W(8), .TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .num_vec(num_vec1),
        .in_valid(in_valid), .a(a), .b(b), .out1(out1), .out2(out2), .out3(out3),
        .busy(busy1), .done(done1), .pass(pass1), .timeout(timeout1),
        .err_pulse(err_pulse1), .vec_cnt(vec_cnt1), .err_cnt(err_cnt1),
        .first_err_idx(first_idx1), .first_err_mask(first_mask1)
    );

    vec_and_resp_checker #(.W(9), .CNT_W(2), .TIMEOUT(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .num_vec(num_vec2),
        .in_valid(in_valid), .a(a), .b(b), .out1(out1), .out2(out2), .out3(out3),
        .busy(busy2), .done(done2), .pass(pass2), .timeout(timeout2),
        .err_pulse(err_pulse2), .vec_cnt(vec_cnt2), .err_cnt(err_cnt2),
        .first_err_idx(first_idx2), .first_err_mask(first_mask2)
    );

    assign o_busy      = sel ? busy2      : busy1;
    assign o_done      = sel ? done2      : done1;
    assign o_pass      = sel ? pass2      : pass1;
    assign o_timeout   = sel ? timeout2   : timeout1;
    assign o_err_pulse = sel ? err_pulse2 : err_pulse1;
    assign o_vec_cnt   = sel ? {6'b0, vec_cnt2}   : vec_cnt1;
    assign o_err_cnt   = sel ? {6'b0, err_cnt2}   : err_cnt1;
    assign o_first_idx = sel ? {6'b0, first_idx2} : first_idx1;
    assign o_mask      = sel ? first_mask2 : first_mask1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, and retire any
    // scoreboard entry due now; otherwise no error pulse may be present.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            checkOutput("err_pulse", {31'b0, o_err_pulse}, {31'b0, e.pulse});
            checkOutput("vec_cnt", {24'b0, o_vec_cnt}, e.vec);
        end else begin
            checkOutput("err_pulse_quiet", {31'b0, o_err_pulse}, 32'd0);
        end
    endtask

    // Drive one vector for one cycle; when the checker should accept it,
    // queue the expected report two edges later.
    task automatic applyStimulus(input logic [8:0] ai, input logic [8:0] bi,
                                 input logic [8:0] o3, input logic o1, input logic o2,
                                 input bit acc);
        logic [8:0] e3;
        logic [2:0] m;
        sb_t        e;
        a        = ai;
        b        = bi;
        out3     = o3;
        out1     = o1;
        out2     = o2;
        in_valid = 1'b1;
        if (acc) begin
            e3 = ai & bi;
            m  = {o3 != e3, o2 != (|e3), o1 != (&e3)};
            model_vec++;
            e.due   = cyc + 2;
            e.pulse = |m;
            e.vec   = model_vec;
            sbq.push_back(e);
        end
        tick();
    endtask

    task automatic idleCycle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic pulseStart(input int n);
        if (sel) begin
            start2   = 1'b1;
            num_vec2 = n[1:0];
        end else begin
            start1   = 1'b1;
            num_vec1 = n[7:0];
        end
        model_vec = 0;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sel = 1'b0;
        a = '0; b = '0; out3 = '0; out1 = 1'b0; out2 = 1'b0;
        start1 = 1'b0; start2 = 1'b0; num_vec1 = '0; num_vec2 = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        $display("[TB] reset state");
        checkOutput("rst_busy", {31'b0, o_busy}, 32'd0);
        checkOutput("rst_done", {31'b0, o_done}, 32'd0);
        checkOutput("rst_pass", {31'b0, o_pass}, 32'd0);
        checkOutput("rst_err_cnt", {24'b0, o_err_cnt}, 32'd0);

        $display("[TB] in_valid while idle");
        applyStimulus(9'h1FF, 9'h1FF, 9'h000, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h0FF, 9'h0F0, 9'h0F0, 1'b0, 1'b1, 1'b0);
        idleCycle();
        checkOutput("idle_vec_cnt", {24'b0, o_vec_cnt}, 32'd0);
        checkOutput("idle_busy", {31'b0, o_busy}, 32'd0);

        $display("[TB] clean run, start together with an idle vector");
        a = 9'h1FF; b = 9'h1FF; out3 = 9'h000; out1 = 1'b0; out2 = 1'b0; in_valid = 1'b1;
        pulseStart(4);
        checkOutput("clean_busy", {31'b0, o_busy}, 32'd1);
        applyStimulus(9'h000, 9'h000, 9'h000, 1'b0, 1'b0, 1'b1);
        applyStimulus(9'h1FF, 9'h000, 9'h000, 1'b0, 1'b0, 1'b1);
        applyStimulus(9'h1FF, 9'h0F0, 9'h0F0, 1'b0, 1'b1, 1'b1);
        applyStimulus(9'h0AA, 9'h0FF, 9'h0AA, 1'b0, 1'b1, 1'b1);
        idleCycle();
        checkOutput("clean_done", {31'b0, o_done}, 32'd1);
        checkOutput("clean_vec_cnt", {24'b0, o_vec_cnt}, 32'd4);
        checkOutput("clean_err_cnt", {24'b0, o_err_cnt}, 32'd0);
        checkOutput("clean_pass", {31'b0, o_pass}, 32'd1);
        checkOutput("clean_timeout", {31'b0, o_timeout}, 32'd0);

        $display("[TB] injected out3 fault, start pulsed mid-run");
        pulseStart(4);
        applyStimulus(9'h000, 9'h000, 9'h000, 1'b0, 1'b0, 1'b1);
        applyStimulus(9'h1FF, 9'h000, 9'h000, 1'b0, 1'b0, 1'b1);
        applyStimulus(9'h1FF, 9'h0F0, 9'h0F1, 1'b0, 1'b1, 1'b1);
        start1 = 1'b1; num_vec1 = 8'd1;
        applyStimulus(9'h0AA, 9'h0FF, 9'h0AA, 1'b0, 1'b1, 1'b1);
        start1 = 1'b0;
        idleCycle();
        checkOutput("fault_done", {31'b0, o_done}, 32'd1);
        checkOutput("fault_err_cnt", {24'b0, o_err_cnt}, 32'd1);
        checkOutput("fault_first_idx", {24'b0, o_first_idx}, 32'd2);
        checkOutput("fault_first_mask", {29'b0, o_mask}, 32'd4);
        checkOutput("fault_pass", {31'b0, o_pass}, 32'd0);

        $display("[TB] idle timeout");
        pulseStart(3);
        applyStimulus(9'h0F0, 9'h0FF, 9'h0F0, 1'b0, 1'b1, 1'b1);
        idleCycle();
        for (int i = 0; i < 6; i++) tick();
        checkOutput("to_not_yet", {31'b0, o_done}, 32'd0);
        tick();
        checkOutput("to_done", {31'b0, o_done}, 32'd1);
        checkOutput("to_timeout", {31'b0, o_timeout}, 32'd1);
        checkOutput("to_vec_cnt", {24'b0, o_vec_cnt}, 32'd1);
        checkOutput("to_pass", {31'b0, o_pass}, 32'd0);

        $display("[TB] zero-length run");
        pulseStart(0);
        checkOutput("zero_busy", {31'b0, o_busy}, 32'd1);
        checkOutput("zero_timeout_cleared", {31'b0, o_timeout}, 32'd0);
        tick();
        checkOutput("zero_done", {31'b0, o_done}, 32'd1);
        checkOutput("zero_pass", {31'b0, o_pass}, 32'd1);
        checkOutput("zero_vec_cnt", {24'b0, o_vec_cnt}, 32'd0);

        $display("[TB] reset mid-run");
        pulseStart(5);
        applyStimulus(9'h1FF, 9'h1FF, 9'h1FF, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        in_valid = 1'b0;
        sbq.delete();
        tick();
        checkOutput("mrst_busy", {31'b0, o_busy}, 32'd0);
        checkOutput("mrst_done", {31'b0, o_done}, 32'd0);
        checkOutput("mrst_vec_cnt", {24'b0, o_vec_cnt}, 32'd0);
        checkOutput("mrst_err_cnt", {24'b0, o_err_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("mrst_stays_idle", {31'b0, o_busy}, 32'd0);

        $display("[TB] reduction fault and saturation on 2-bit counters");
        sel = 1'b1;
        pulseStart(3);
        for (int i = 0; i < 3; i++) applyStimulus(9'h1FF, 9'h1FF, 9'h1FF, 1'b0, 1'b1, 1'b1);
        idleCycle();
        checkOutput("sat_done", {31'b0, o_done}, 32'd1);
        checkOutput("sat_err_cnt", {24'b0, o_err_cnt}, 32'd3);
        checkOutput("sat_first_idx", {24'b0, o_first_idx}, 32'd0);
        checkOutput("sat_first_mask", {29'b0, o_mask}, 32'd1);
        checkOutput("sat_pass", {31'b0, o_pass}, 32'd0);
        pulseStart(3);
        checkOutput("sat_cleared", {24'b0, o_err_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(9'h1FF, 9'h1FF, 9'h1FF, 1'b0, 1'b1, 1'b1);
        idleCycle();
        checkOutput("sat2_err_cnt", {24'b0, o_err_cnt}, 32'd3);
        checkOutput("sat2_done", {31'b0, o_done}, 32'd1);
        checkOutput("sb_empty", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
